vpu_issue_scheduler: RTL and testbench

- Shares the VPU datapath issue port among NUM_REQ command requesters using round-robin arbitration.
- Enforces two minimum-spacing rules with internal saturating down-counters:
  - a global gap between any two issues;
  - a per-command-type gap between issues of the same type.
- Sits between the command front-ends and the VPU datapath. It is the sole issuer of datapath commands.

---
 rtl/vpu_issue_scheduler_if.sv | 31 +++
 rtl/vpu_issue_scheduler.sv | 136 +++++++++++++
 tb/tb_vpu_issue_scheduler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/vpu_issue_scheduler_if.sv
// Request-side bus between the command front-ends and the issue scheduler.
// Carries per-requester valid/type/payload and the one-hot accept back.
// Signal suffixes are from the scheduler's point of view (slave modport).
interface vpu_issue_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_TYPE  = 4,
  parameter int PAYLOAD_W = 32
);
  localparam int TW = $clog2(NUM_TYPE);

  logic [NUM_REQ-1:0]           req_valid_i;
  logic [NUM_REQ-1:0]           req_ready_o;
  logic [NUM_REQ*TW-1:0]        req_type_i;
  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload_i;

  // Front-ends drive commands and observe the accept.
  modport master (
    output req_valid_i,
    output req_type_i,
    output req_payload_i,
    input  req_ready_o
  );

  // The scheduler observes commands and drives the accept.
  modport slave (
    input  req_valid_i,
    input  req_type_i,
    input  req_payload_i,
    output req_ready_o
  );
endinterface

// File: rtl/vpu_issue_scheduler.sv
// Round-robin issue scheduler for the VPU datapath with global and per-type issue spacing.
// Latency: accept is combinational; the issue strobe and its fields appear one cycle after the accept.
// Backpressure: issue_stall_i or !sched_en_i withholds every accept; gap counters keep draining meanwhile.
module vpu_issue_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_TYPE   = 4,
  parameter int PAYLOAD_W  = 32,
  parameter int CNTR_WIDTH = 4,
  localparam int TW = $clog2(NUM_TYPE),
  localparam int SW = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sched_en_i,
  input  logic                           issue_stall_i,
  vpu_issue_scheduler_if.slave           req,
  input  logic [CNTR_WIDTH-1:0]          cfg_gap_any_i,
  input  logic [NUM_TYPE*CNTR_WIDTH-1:0] cfg_gap_same_i,
  output logic                           issue_valid_o,
  output logic [TW-1:0]                  issue_type_o,
  output logic [SW-1:0]                  issue_src_o,
  output logic [PAYLOAD_W-1:0]           issue_payload_o,
  output logic                           busy_o
);

  logic [CNTR_WIDTH-1:0] cnt_any_q, cnt_any_d;
  logic [CNTR_WIDTH-1:0] cnt_type_q [NUM_TYPE];
  logic [CNTR_WIDTH-1:0] cnt_type_d [NUM_TYPE];
  logic [SW-1:0]         rr_q, rr_d;

  logic                  issue_valid_q;
  logic [TW-1:0]         issue_type_q;
  logic [SW-1:0]         issue_src_q;
  logic [PAYLOAD_W-1:0]  issue_payload_q;

  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    grant;
  logic                  xfer;
  logic [SW-1:0]         gnt_idx;
  logic [TW-1:0]         gnt_type;
  logic [PAYLOAD_W-1:0]  gnt_payload;
  logic                  busy;

  // A requester is eligible only when both of its gap counters have drained and issue is allowed;
  // reset suppresses eligibility so no accept is signalled in a cycle whose grant would be dropped.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req.req_valid_i[i]
             && (cnt_any_q == '0)
             && (cnt_type_q[req.req_type_i[i*TW +: TW]] == '0)
             && sched_en_i
             && !issue_stall_i
             && !rst;
    end
  end

  // Pick the first eligible requester at or above the RR pointer, wrapping; blocked ones are skipped.
  always_comb begin
    logic [SW-1:0] idx;
    grant       = '0;
    xfer        = 1'b0;
    gnt_idx     = '0;
    gnt_type    = '0;
    gnt_payload = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_q + SW'(k);
      if (!xfer && elig[idx]) begin
        xfer        = 1'b1;
        grant[idx]  = 1'b1;
        gnt_idx     = idx;
        gnt_type    = req.req_type_i[idx*TW +: TW];
        gnt_payload = req.req_payload_i[idx*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  assign req.req_ready_o = grant;

  // Gap counters drain toward zero and reload on an issue; a reload only ever hits a counter already at zero.
  always_comb begin
    cnt_any_d = (cnt_any_q != '0) ? cnt_any_q - CNTR_WIDTH'(1) : cnt_any_q;
    for (int t = 0; t < NUM_TYPE; t++) begin
      cnt_type_d[t] = (cnt_type_q[t] != '0) ? cnt_type_q[t] - CNTR_WIDTH'(1) : cnt_type_q[t];
    end
    rr_d = rr_q;
    if (xfer) begin
      cnt_any_d            = cfg_gap_any_i;
      cnt_type_d[gnt_type] = cfg_gap_same_i[gnt_type*CNTR_WIDTH +: CNTR_WIDTH];
      rr_d                 = gnt_idx + SW'(1);
    end
  end

  // State and issue registers; issue fields other than the strobe keep the last issued command.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_any_q       <= '0;
      for (int t = 0; t < NUM_TYPE; t++) begin
        cnt_type_q[t] <= '0;
      end
      rr_q            <= '0;
      issue_valid_q   <= 1'b0;
      issue_type_q    <= '0;
      issue_src_q     <= '0;
      issue_payload_q <= '0;
    end else begin
      cnt_any_q       <= cnt_any_d;
      for (int t = 0; t < NUM_TYPE; t++) begin
        cnt_type_q[t] <= cnt_type_d[t];
      end
      rr_q            <= rr_d;
      issue_valid_q   <= xfer;
      if (xfer) begin
        issue_type_q    <= gnt_type;
        issue_src_q     <= gnt_idx;
        issue_payload_q <= gnt_payload;
      end
    end
  end

  // Busy reflects only registered counter state.
  always_comb begin
    busy = (cnt_any_q != '0);
    for (int t = 0; t < NUM_TYPE; t++) begin
      busy = busy || (cnt_type_q[t] != '0);
    end
  end

  assign issue_valid_o   = issue_valid_q;
  assign issue_type_o    = issue_type_q;
  assign issue_src_o     = issue_src_q;
  assign issue_payload_o = issue_payload_q;
  assign busy_o          = busy;

endmodule

// File: tb/tb_vpu_issue_scheduler.sv
// Directed bench for vpu_issue_scheduler: table of per-cycle vectors plus hand-written sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
// Expected values are hand-computed from the scheduling rules.
module tb_vpu_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        sched_en;
  logic        stall;
  logic [3:0]  gap_any;
  logic [15:0] gap_same;
  logic        iv;
  logic [1:0]  ityp;
  logic [1:0]  isrc;
  logic [31:0] ipay;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vpu_issue_scheduler_if #(.NUM_REQ(4), .NUM_TYPE(4), .PAYLOAD_W(32)) rif ();

  vpu_issue_scheduler #(
    .NUM_REQ(4), .NUM_TYPE(4), .PAYLOAD_W(32), .CNTR_WIDTH(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sched_en_i     (sched_en),
    .issue_stall_i  (stall),
    .req            (rif),
    .cfg_gap_any_i  (gap_any),
    .cfg_gap_same_i (gap_same),
    .issue_valid_o  (iv),
    .issue_type_o   (ityp),
    .issue_src_o    (isrc),
    .issue_payload_o(ipay),
    .busy_o         (busy)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [7:0]  typ;
    logic [3:0]  g;
    logic [15:0] s;
    logic [3:0]  x_rdy;
    logic        x_iv;
    logic [1:0]  x_src;
    logic [1:0]  x_typ;
    logic        x_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] vld, input logic [7:0] typ,
                              input logic [3:0] g, input logic [15:0] s,
                              input logic [3:0] rdy, input logic xiv,
                              input logic [1:0] src, input logic [1:0] ty, input logic bz);
    vec_t v;
    v.vld = vld; v.typ = typ; v.g = g; v.s = s;
    v.x_rdy = rdy; v.x_iv = xiv; v.x_src = src; v.x_typ = ty; v.x_busy = bz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Payload of requester i is a fixed tag so the issued payload identifies its source.
  function automatic logic [31:0] pay_of(input logic [1:0] src);
    return 32'hC0DE_0000 | 32'(src);
  endfunction

  task automatic check_outs(input string tag, input logic [3:0] rdy, input logic xiv,
                            input logic [1:0] src, input logic [1:0] ty, input logic bz);
    chk({tag, ".ready"}, 32'(rif.req_ready_o), 32'(rdy));
    chk({tag, ".issue_valid"}, 32'(iv), 32'(xiv));
    chk({tag, ".issue_src"}, 32'(isrc), 32'(src));
    chk({tag, ".issue_type"}, 32'(ityp), 32'(ty));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    if (xiv) chk({tag, ".payload"}, ipay, pay_of(src));
  endtask

  // One clock cycle of stimulus; returns mid-cycle, ready for sampling.
  task automatic step(input logic r, input logic e, input logic st, input logic [3:0] vld,
                      input logic [7:0] typ, input logic [3:0] g, input logic [15:0] s);
    @(posedge clk);
    #1;
    rst = r; sched_en = e; stall = st;
    rif.req_valid_i = vld; rif.req_type_i = typ;
    gap_any = g; gap_same = s;
    #4;
  endtask

  initial begin
    rst = 1'b1; sched_en = 1'b1; stall = 1'b0;
    gap_any = '0; gap_same = '0;
    rif.req_valid_i   = '0;
    rif.req_type_i    = '0;
    rif.req_payload_i = {pay_of(2'd3), pay_of(2'd2), pay_of(2'd1), pay_of(2'd0)};

    // Idle after reset
    vecs.push_back(mk(4'b0000, 8'h00, 4'd0, 16'h0000, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 8'h00, 4'd0, 16'h0000, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0));
    // Single requester, G=0, S[0]=3: issues every 4 cycles
    vecs.push_back(mk(4'b0001, 8'h00, 4'd0, 16'h0003, 4'b0001, 1'b0, 2'd0, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0001, 8'h00, 4'd0, 16'h0003, 4'b0000, 1'b1, 2'd0, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0001, 8'h00, 4'd0, 16'h0003, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0001, 8'h00, 4'd0, 16'h0003, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0001, 8'h00, 4'd0, 16'h0003, 4'b0001, 1'b0, 2'd0, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0001, 8'h00, 4'd0, 16'h0003, 4'b0000, 1'b1, 2'd0, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0001, 8'h00, 4'd0, 16'h0003, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0001, 8'h00, 4'd0, 16'h0003, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0001, 8'h00, 4'd0, 16'h0003, 4'b0001, 1'b0, 2'd0, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 8'h00, 4'd0, 16'h0003, 4'b0000, 1'b1, 2'd0, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0000, 8'h00, 4'd0, 16'h0003, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0000, 8'h00, 4'd0, 16'h0003, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0000, 8'h00, 4'd0, 16'h0003, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0));
    // Round robin, all valid, distinct types, no gaps; pointer starts at 1
    vecs.push_back(mk(4'b1111, 8'hE4, 4'd0, 16'h0000, 4'b0010, 1'b0, 2'd0, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1111, 8'hE4, 4'd0, 16'h0000, 4'b0100, 1'b1, 2'd1, 2'd1, 1'b0));
    vecs.push_back(mk(4'b1111, 8'hE4, 4'd0, 16'h0000, 4'b1000, 1'b1, 2'd2, 2'd2, 1'b0));
    vecs.push_back(mk(4'b1111, 8'hE4, 4'd0, 16'h0000, 4'b0001, 1'b1, 2'd3, 2'd3, 1'b0));
    vecs.push_back(mk(4'b1111, 8'hE4, 4'd0, 16'h0000, 4'b0010, 1'b1, 2'd0, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1111, 8'hE4, 4'd0, 16'h0000, 4'b0100, 1'b1, 2'd1, 2'd1, 1'b0));
    vecs.push_back(mk(4'b1111, 8'hE4, 4'd0, 16'h0000, 4'b1000, 1'b1, 2'd2, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 8'hE4, 4'd0, 16'h0000, 4'b0000, 1'b1, 2'd3, 2'd3, 1'b0));
    // Per-type blocking: G=1, S[1]=5; req0,req1 type 1, req2 type 2; pointer at 0
    vecs.push_back(mk(4'b0111, 8'h25, 4'd1, 16'h0050, 4'b0001, 1'b0, 2'd3, 2'd3, 1'b0));
    vecs.push_back(mk(4'b0110, 8'h25, 4'd1, 16'h0050, 4'b0000, 1'b1, 2'd0, 2'd1, 1'b1));
    vecs.push_back(mk(4'b0110, 8'h25, 4'd1, 16'h0050, 4'b0100, 1'b0, 2'd0, 2'd1, 1'b1));
    vecs.push_back(mk(4'b0010, 8'h25, 4'd1, 16'h0050, 4'b0000, 1'b1, 2'd2, 2'd2, 1'b1));
    vecs.push_back(mk(4'b0010, 8'h25, 4'd1, 16'h0050, 4'b0000, 1'b0, 2'd2, 2'd2, 1'b1));
    vecs.push_back(mk(4'b0010, 8'h25, 4'd1, 16'h0050, 4'b0000, 1'b0, 2'd2, 2'd2, 1'b1));
    vecs.push_back(mk(4'b0010, 8'h25, 4'd1, 16'h0050, 4'b0010, 1'b0, 2'd2, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 8'h25, 4'd1, 16'h0050, 4'b0000, 1'b1, 2'd1, 2'd1, 1'b1));

    // Reset held for two edges, then sample reset state before release
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset.issue_valid", 32'(iv), 32'd0);
    chk("reset.issue_type", 32'(ityp), 32'd0);
    chk("reset.issue_src", 32'(isrc), 32'd0);
    chk("reset.payload", ipay, 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.ready", 32'(rif.req_ready_o), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b0, 1'b1, 1'b0, vecs[i].vld, vecs[i].typ, vecs[i].g, vecs[i].s);
      check_outs($sformatf("vec%0d", i), vecs[i].x_rdy, vecs[i].x_iv,
                 vecs[i].x_src, vecs[i].x_typ, vecs[i].x_busy);
    end

    // Reset mid-operation: counters at cnt_any=2, cnt_type[0]=4 when reset hits
    step(1'b1, 1'b1, 1'b0, 4'b0000, 8'h04, 4'd2, 16'h0004);
    step(1'b0, 1'b1, 1'b0, 4'b0001, 8'h04, 4'd2, 16'h0004);
    check_outs("mrst.first", 4'b0001, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 8'h04, 4'd2, 16'h0004);
    check_outs("mrst.during", 4'b0000, 1'b1, 2'd0, 2'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'b0011, 8'h04, 4'd2, 16'h0004);
    check_outs("mrst.after", 4'b0001, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'b0000, 8'h04, 4'd2, 16'h0004);
    check_outs("mrst.issue", 4'b0000, 1'b1, 2'd0, 2'd0, 1'b1);

    // Stall then disable with G=2 after an issue from requester 1
    step(1'b1, 1'b1, 1'b0, 4'b0000, 8'hE4, 4'd2, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 4'b0010, 8'hE4, 4'd2, 16'h0000);
    check_outs("stall.issue", 4'b0010, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'b1111, 8'hE4, 4'd2, 16'h0000);
    check_outs("stall.c1", 4'b0000, 1'b1, 2'd1, 2'd1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 4'b1111, 8'hE4, 4'd2, 16'h0000);
    check_outs("stall.c2", 4'b0000, 1'b0, 2'd1, 2'd1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 4'b1111, 8'hE4, 4'd2, 16'h0000);
    check_outs("stall.c3", 4'b0000, 1'b0, 2'd1, 2'd1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'b1111, 8'hE4, 4'd2, 16'h0000);
    check_outs("dis.c1", 4'b0000, 1'b0, 2'd1, 2'd1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'b1111, 8'hE4, 4'd2, 16'h0000);
    check_outs("dis.c2", 4'b0000, 1'b0, 2'd1, 2'd1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'b1111, 8'hE4, 4'd2, 16'h0000);
    check_outs("resume", 4'b0100, 1'b0, 2'd1, 2'd1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'b0000, 8'hE4, 4'd2, 16'h0000);
    check_outs("resume.issue", 4'b0000, 1'b1, 2'd2, 2'd2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
